mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bus between the instruction-fetch requester and the data (load/store) requester of the five-stage RV32 pipeline.
- Arbitrates between the two requesters, with data taking priority and a starvation guard protecting fetch.
- Sequences each transaction through a request/accept/response handshake.
- Returns read data or write acknowledges to the owning requester, and raises per-requester stall so the pipeline freezes while an access is outstanding.
- Detects a hung memory through a timeout.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants taken while fetch is waiting; once reached, fetch is forced to win the next arbitration.
- TIMEOUT_CYCLES, 255: cycles allowed in REQ or WAIT_RSP before the transaction is aborted.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset
- if_req_i  in  1  fetch request; held until if_gnt_o
- if_addr_i  in  32  fetch address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse)
- if_rdata_o  out  32  fetched instruction
- if_stall_o  out  1  fetch pending or outstanding
- d_rd_i  in  1  load request; held until d_gnt_o
- d_wr_i  in  1  store request; held until d_gnt_o
- d_addr_i  in  32  data address
- d_wdata_i  in  32  store data
- d_be_i  in  4  store byte enables
- d_gnt_o  out  1  data request accepted (1-cycle pulse)
- d_rvalid_o  out  1  load data valid or store complete (1-cycle pulse)
- d_rdata_o  out  32  load data
- d_stall_o  out  1  data pending or outstanding
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_addr_o  out  32  bus address
- mem_wdata_o  out  32  bus write data
- mem_be_o  out  4  bus byte enables
- mem_ready_i  in  1  bus accepts request this cycle
- mem_rvalid_i  in  1  bus read data valid
- mem_rdata_i  in  32  bus read data
- err_o  out  1  sticky timeout flag

Behaviour:
- Single clock clk_i. Reset reset_i is synchronous, active-high.
- Reset, including mid-transaction:
  - State returns to IDLE; all counters clear.
  - Every output is 0, including err_o. In-flight data is discarded.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE arbitration (combinational):
  - Data (d_rd_i|d_wr_i) beats fetch.
  - Exception: fetch wins when if_req_i=1 and starve_cnt==STARVE_LIMIT.
  - Winner's gnt pulses in the same cycle. Its address, wdata, be and type are latched; owner is recorded; state goes to REQ.
  - If d_rd_i and d_wr_i are both high, the access is treated as a write.
- starve_cnt:
  - Increments on a data grant while if_req_i=1, saturating at STARVE_LIMIT.
  - Clears on a fetch grant.
- REQ:
  - mem_req_o=1 with the latched fields stable until mem_ready_i=1.
  - On acceptance of a write: owner's rvalid pulses next cycle; state goes to IDLE.
  - On acceptance of a read: state goes to WAIT_RSP.
  - mem_req_o is 0 in all other states.
- WAIT_RSP:
  - On mem_rvalid_i=1, mem_rdata_i is registered into the owner's rdata and the owner's rvalid pulses in the next cycle; state goes to IDLE.
  - mem_rvalid_i outside WAIT_RSP is ignored.
- Latency (grant in cycle N, zero-wait memory):
  - mem_req_o is high in N+1.
  - Read: mem_rvalid_i in N+2, rvalid_o in N+3.
  - Write: rvalid_o in N+2.
  - A new grant is possible in the cycle state re-enters IDLE.
- rdata_o holds its value until the owner's next read completes.
- stall:
  - x_stall_o = x request asserted and not yet granted, OR x owns the current transaction and its rvalid has not yet pulsed.
  - stall deasserts in the same cycle as rvalid_o.
- Timeout:
  - tmo_cnt clears on entry to REQ and increments each cycle in REQ or WAIT_RSP.
  - At TIMEOUT_CYCLES: state aborts to IDLE; owner's rvalid pulses with rdata=0; err_o sets and stays set until reset.
- Addresses are passed unmodified; the block does no alignment checks.

Test Plan:
- Fetch only, addr 0x100, mem_ready_i=1 on first cycle, mem_rvalid_i next cycle with 0x00000013 -> if_gnt_o in N, mem_req_o in N+1, if_rvalid_o in N+3 with if_rdata_o=0x00000013, if_stall_o low in N+3.
- Store, addr 0x2000, wdata 0xDEADBEEF, be 4'b1111, mem_ready_i delayed 3 cycles -> mem_* stable for 3 cycles, mem_we_o=1, d_rvalid_o one cycle after acceptance, d_stall_o high throughout until then.
- Fetch and data requests held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt clears after each fetch grant.
- Simultaneous d_rd_i=1 and d_wr_i=1 -> single bus write issued, no read.
- Read with mem_ready_i=1 but mem_rvalid_i never asserted, TIMEOUT_CYCLES=8 -> abort after 8 cycles, owner rvalid pulses with rdata=0, err_o=1 and remains set until reset.
- reset_i asserted while in WAIT_RSP, then mem_rvalid_i arrives -> all outputs 0, state IDLE, no rvalid pulse, err_o=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and data requesters with starvation guard and timeout
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_stall_o,
  input  logic        d_rd_i,
  input  logic        d_wr_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;
  state_t state;
  logic own_d;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic d_req, if_win, busy, rd_done, done, abort;
  assign d_req = d_rd_i | d_wr_i;
  assign if_win = if_req_i & (!d_req | starve_cnt == SLIM);
  assign if_gnt_o = !reset_i & state == IDLE & if_win;
  assign d_gnt_o = !reset_i & state == IDLE & d_req & !if_win;
  assign busy = state != IDLE;
  assign mem_req_o = state == REQ;
  assign rd_done = state == WAIT_RSP & mem_rvalid_i;
  assign done = rd_done | (mem_req_o & mem_ready_i & mem_we_o);
  assign abort = busy & tmo_cnt == TLAST & !done;
  assign if_stall_o = !reset_i & ((if_req_i & !if_gnt_o) | (busy & !own_d));
  assign d_stall_o = !reset_i & ((d_req & !d_gnt_o) | (busy & own_d));
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      own_d <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt <= '0;
      if_rvalid_o <= 1'b0;
      d_rvalid_o <= 1'b0;
      if_rdata_o <= '0;
      d_rdata_o <= '0;
      err_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      mem_be_o <= '0;
    end else begin
      if_rvalid_o <= 1'b0;
      d_rvalid_o <= 1'b0;
      tmo_cnt <= busy ? tmo_cnt + 1'b1 : '0;
      if (if_gnt_o)
        starve_cnt <= '0;
      else if (d_gnt_o & if_req_i & starve_cnt != SLIM)
        starve_cnt <= starve_cnt + 1'b1;
      if (if_gnt_o | d_gnt_o) begin
        state <= REQ;
        own_d <= d_gnt_o;
        mem_we_o <= d_gnt_o & d_wr_i;
        mem_addr_o <= d_gnt_o ? d_addr_i : if_addr_i;
        mem_wdata_o <= d_gnt_o ? d_wdata_i : '0;
        mem_be_o <= d_gnt_o ? d_be_i : 4'hf;
      end else if (done | abort) begin
        state <= IDLE;
        if_rvalid_o <= !own_d;
        d_rvalid_o <= own_d;
        err_o <= err_o | abort;
        if ((rd_done | abort) & !own_d)
          if_rdata_o <= abort ? '0 : mem_rdata_i;
        if ((rd_done | abort) & own_d)
          d_rdata_o <= abort ? '0 : mem_rdata_i;
      end else if (mem_req_o & mem_ready_i) begin
        state <= WAIT_RSP;
      end
    end
  end
endmodule
